// File: rtl/median_window_3x3_gen_if.sv
// Pixel-stream in / 3x3 window out bundle between a raster source and the
// median sorter front end.
interface median_window_3x3_gen_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] pix_in;
  logic              pix_valid;
  logic              sof;
  logic [DATA_W-1:0] x1, x2, x3, x4, x5, x6, x7, x8, x9;
  logic              win_valid;
  logic              eof;

  modport master (
    output pix_in, pix_valid, sof,
    input  x1, x2, x3, x4, x5, x6, x7, x8, x9, win_valid, eof
  );

  modport slave (
    input  pix_in, pix_valid, sof,
    output x1, x2, x3, x4, x5, x6, x7, x8, x9, win_valid, eof
  );
endinterface

// File: rtl/median_window_3x3_gen.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus a 3x3 tap
// shift register, emitting one registered window per interior pixel.
module median_window_3x3_gen #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480
) (
  input  logic                    clk,
  input  logic                    rst_n,
  median_window_3x3_gen_if.slave  s
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_ONE = COL_W'(1);
  localparam logic [ROW_W-1:0] ROW_ONE = ROW_W'(1);
  localparam logic [COL_W-1:0] COL_TWO = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_TWO = ROW_W'(2);

  logic [COL_W-1:0]  col_q, col_d, c_s;
  logic [ROW_W-1:0]  row_q, row_d, r_s;
  logic [DATA_W-1:0] lb0_q [IMG_W];
  logic [DATA_W-1:0] lb1_q [IMG_W];
  logic [DATA_W-1:0] top_s, mid_s;
  logic              lb_we_s;
  logic [DATA_W-1:0] tap_q [9];
  logic [DATA_W-1:0] tap_d [9];
  logic              win_valid_q, win_valid_d;
  logic              eof_q, eof_d;

  // Effective coordinates, line-buffer reads and next-state for taps/counters.
  always_comb begin
    if (s.sof) begin
      c_s = '0;
      r_s = '0;
    end else begin
      c_s = col_q;
      r_s = row_q;
    end
    top_s       = lb1_q[c_s];
    mid_s       = lb0_q[c_s];
    col_d       = col_q;
    row_d       = row_q;
    tap_d       = tap_q;
    win_valid_d = 1'b0;
    eof_d       = 1'b0;
    lb_we_s     = 1'b0;
    if (s.pix_valid) begin
      lb_we_s     = 1'b1;
      tap_d[0]    = tap_q[1];
      tap_d[1]    = tap_q[2];
      tap_d[2]    = top_s;
      tap_d[3]    = tap_q[4];
      tap_d[4]    = tap_q[5];
      tap_d[5]    = mid_s;
      tap_d[6]    = tap_q[7];
      tap_d[7]    = tap_q[8];
      tap_d[8]    = s.pix_in;
      // Columns 0 and 1 hold the previous line's tail in the taps; never valid.
      win_valid_d = (r_s >= ROW_TWO) && (c_s >= COL_TWO);
      eof_d       = (r_s == ROW_MAX) && (c_s == COL_MAX);
      if (c_s == COL_MAX) begin
        col_d = '0;
        if (r_s == ROW_MAX) begin
          row_d = '0;
        end else begin
          row_d = r_s + ROW_ONE;
        end
      end else begin
        col_d = c_s + COL_ONE;
        row_d = r_s;
      end
    end else begin
      col_d       = col_q;
      row_d       = row_q;
      tap_d       = tap_q;
      win_valid_d = 1'b0;
      eof_d       = 1'b0;
      lb_we_s     = 1'b0;
    end
  end

  // Counters, taps and strobes with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      win_valid_q <= 1'b0;
      eof_q       <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        tap_q[i] <= '0;
      end
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      win_valid_q <= win_valid_d;
      eof_q       <= eof_d;
      tap_q       <= tap_d;
    end
  end

  // Line buffers carry no reset; stale content is never flagged valid.
  always_ff @(posedge clk) begin
    if (lb_we_s) begin
      lb1_q[c_s] <= mid_s;
      lb0_q[c_s] <= s.pix_in;
    end
  end

  assign s.x1        = tap_q[0];
  assign s.x2        = tap_q[1];
  assign s.x3        = tap_q[2];
  assign s.x4        = tap_q[3];
  assign s.x5        = tap_q[4];
  assign s.x6        = tap_q[5];
  assign s.x7        = tap_q[6];
  assign s.x8        = tap_q[7];
  assign s.x9        = tap_q[8];
  assign s.win_valid = win_valid_q;
  assign s.eof       = eof_q;

endmodule

// File: tb/tb_median_window_3x3_gen.sv
// Self-checking bench for median_window_3x3_gen on a 4x4 image: fixed vector
// tables, hand-written corner sequences and randomized frames vs a frame model.
module tb_median_window_3x3_gen;

  localparam int W = 4;
  localparam int H = 4;

  typedef struct {
    logic        v;
    logic        s;
    logic [7:0]  pix;
    logic        exp_wv;
    logic        exp_eof;
    logic [71:0] exp_win;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  int   win_cnt;

  median_window_3x3_gen_if #(.DATA_W(8)) bus ();

  median_window_3x3_gen #(.DATA_W(8), .IMG_W(W), .IMG_H(H)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the whole frame as a 2-D image plus raster coordinates.
  int          img [H][W];
  int          mr, mc;
  logic        taps_known;
  logic [71:0] last_win;

  task automatic model_reset();
    mr = 0;
    mc = 0;
    taps_known = 1'b0;
    last_win = 72'd0;
  endtask

  task automatic model_step(input logic v, input logic s, input logic [7:0] p,
                            output logic ewv, output logic eeof,
                            output logic [71:0] ewin, output logic ct);
    ewv = 1'b0;
    eeof = 1'b0;
    ewin = last_win;
    ct = 1'b0;
    if (!v) begin
      ct = taps_known;
    end else begin
      if (s) begin
        mr = 0;
        mc = 0;
      end
      img[mr][mc] = int'(p);
      ewv = (mr >= 2) && (mc >= 2);
      eeof = (mr == H - 1) && (mc == W - 1);
      if (ewv) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            ewin[71 - 8 * (3 * i + j) -: 8] = 8'(img[mr - 2 + i][mc - 2 + j]);
        last_win = ewin;
      end
      ct = ewv;
      taps_known = ewv;
      mc = mc + 1;
      if (mc == W) begin
        mc = 0;
        mr = (mr + 1) % H;
      end
    end
  endtask

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_check(input logic v, input logic s, input logic [7:0] p,
                             input logic ewv, input logic eeof, input logic [71:0] ewin,
                             input logic ctaps, input string tag);
    bus.pix_valid = v;
    bus.sof = s;
    bus.pix_in = p;
    @(negedge clk);
    chk({tag, " win_valid"}, 72'(bus.win_valid), 72'(ewv));
    chk({tag, " eof"}, 72'(bus.eof), 72'(eeof));
    if (bus.win_valid === 1'b1) win_cnt++;
    if (ctaps)
      chk({tag, " taps"}, {bus.x1, bus.x2, bus.x3, bus.x4, bus.x5, bus.x6,
                           bus.x7, bus.x8, bus.x9}, ewin);
  endtask

  task automatic model_cycle(input logic v, input logic s, input logic [7:0] p, input string tag);
    logic ewv, eeof, ct;
    logic [71:0] ewin;
    model_step(v, s, p, ewv, eeof, ewin, ct);
    drive_check(v, s, p, ewv, eeof, ewin, ct, tag);
  endtask

  function automatic logic [71:0] win_of(input int base, input int tl);
    return {8'(base + tl), 8'(base + tl + 1), 8'(base + tl + 2),
            8'(base + tl + 4), 8'(base + tl + 5), 8'(base + tl + 6),
            8'(base + tl + 8), 8'(base + tl + 9), 8'(base + tl + 10)};
  endfunction

  task automatic run_table(input int base, input logic first_sof, input string tag);
    vec_t tbl [16];
    logic mwv, meof, mct;
    logic [71:0] mwin;
    for (int i = 0; i < 16; i++)
      tbl[i] = '{1'b1, (i == 0) && first_sof, 8'(base + i), 1'b0, (i == 15), 72'd0};
    tbl[10].exp_wv = 1'b1; tbl[10].exp_win = win_of(base, 0);
    tbl[11].exp_wv = 1'b1; tbl[11].exp_win = win_of(base, 1);
    tbl[14].exp_wv = 1'b1; tbl[14].exp_win = win_of(base, 4);
    tbl[15].exp_wv = 1'b1; tbl[15].exp_win = win_of(base, 5);
    win_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      model_step(tbl[i].v, tbl[i].s, tbl[i].pix, mwv, meof, mwin, mct);
      drive_check(tbl[i].v, tbl[i].s, tbl[i].pix, tbl[i].exp_wv, tbl[i].exp_eof,
                  tbl[i].exp_win, tbl[i].exp_wv, $sformatf("%s px%0d", tag, i));
    end
    chk({tag, " window count"}, 72'(win_cnt), 72'd4);
  endtask

  task automatic run_frame(input int base, input int gap_pct, input string tag);
    win_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      while ($urandom_range(99) < gap_pct)
        model_cycle(1'b0, 1'b0, 8'($urandom), {tag, " gap"});
      model_cycle(1'b1, i == 0, 8'(base + i), $sformatf("%s px%0d", tag, i));
    end
    chk({tag, " window count"}, 72'(win_cnt), 72'd4);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    win_cnt = 0;
    rst_n = 1'b0;
    bus.pix_valid = 1'b0;
    bus.sof = 1'b0;
    bus.pix_in = 8'd0;
    model_reset();
    #2;
    chk("reset win_valid", 72'(bus.win_valid), 72'd0);
    chk("reset eof", 72'(bus.eof), 72'd0);
    chk("reset taps", {bus.x1, bus.x2, bus.x3, bus.x4, bus.x5, bus.x6,
                       bus.x7, bus.x8, bus.x9}, 72'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_table(0, 1'b1, "frame0");
    run_frame(0, 40, "gapped");
    run_table(100, 1'b1, "frame100");

    // Abandoned partial frame followed by a fresh sof.
    for (int i = 0; i < 6; i++)
      model_cycle(1'b1, i == 0, 8'(50 + i), $sformatf("partial px%0d", i));
    run_frame(60, 0, "after_sof");

    // Randomized frames with gaps and occasional mid-frame restarts.
    for (int f = 0; f < 8; f++) begin
      int k;
      int guard;
      k = 0;
      guard = 0;
      while (k < 16 && guard < 300) begin
        guard++;
        if (k > 0 && $urandom_range(29) == 0) k = 0;
        while ($urandom_range(99) < 25)
          model_cycle(1'b0, 1'b0, 8'($urandom), "rand gap");
        model_cycle(1'b1, k == 0, 8'($urandom), $sformatf("rand f%0d k%0d", f, k));
        k++;
      end
    end

    // Asynchronous reset while a window is on the outputs.
    for (int i = 0; i <= 10; i++)
      model_cycle(1'b1, i == 0, 8'(30 + i), $sformatf("pre_rst px%0d", i));
    chk("pre_rst win_valid high", 72'(bus.win_valid), 72'd1);
    #2;
    rst_n = 1'b0;
    bus.pix_valid = 1'b0;
    #1;
    chk("async rst win_valid", 72'(bus.win_valid), 72'd0);
    chk("async rst eof", 72'(bus.eof), 72'd0);
    chk("async rst taps", {bus.x1, bus.x2, bus.x3, bus.x4, bus.x5, bus.x6,
                           bus.x7, bus.x8, bus.x9}, 72'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    run_table(0, 1'b0, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
